// File: rtl/la_iosequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : la_iosequencer_pkg
// Description : Ring power levels and the level-to-enable thermometer decode
//               shared by the IO power sequencer.
// Revision    : 1.0
// ============================================================================
package la_iosequencer_pkg;

    localparam int LVL_W = 3;
    localparam int NSTEP = 6;

    typedef logic [LVL_W-1:0] lvl_t;

    localparam lvl_t LVL_OFF   = 3'd0;
    localparam lvl_t LVL_VDDIO = 3'd1;
    localparam lvl_t LVL_H     = 3'd2;
    localparam lvl_t LVL_VDDA  = 3'd3;
    localparam lvl_t LVL_VSW   = 3'd4;
    localparam lvl_t LVL_INP   = 3'd5;
    localparam lvl_t LVL_ON    = 3'd6;

    // Bit k-1 is the ring control for step k, set once the level reaches k.
    function automatic logic [NSTEP-1:0] lvl_therm(input lvl_t lvl);
        logic [NSTEP-1:0] t;
        t[0] = (lvl >= LVL_VDDIO);
        t[1] = (lvl >= LVL_H);
        t[2] = (lvl >= LVL_VDDA);
        t[3] = (lvl >= LVL_VSW);
        t[4] = (lvl >= LVL_INP);
        t[5] = (lvl >= LVL_ON);
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/la_dsync.sv
`default_nettype none
// ============================================================================
// Module      : la_dsync
// Description : Two-flop synchronizer for asynchronous level inputs.
// Revision    : 1.0
// ============================================================================
module la_dsync #(
    parameter PROP = "DEFAULT"
) (
    input  logic clk,
    input  logic nreset,
    input  logic in,
    output logic out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= in;
            r_sync <= r_meta;
        end
    end

    assign out = r_sync;

endmodule
`default_nettype wire

// File: rtl/la_iosequencer.sv
`default_nettype none
// ============================================================================
// Module      : la_iosequencer
// Description : Timed power-up/power-down sequencer for the sky130 IO ring
//               enables and pad hold, with forced-safe on IO supply loss.
// Revision    : 1.0
// ============================================================================
module la_iosequencer
    import la_iosequencer_pkg::*;
#(
    parameter     PROP = "DEFAULT",
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en,
    input  logic          vddio_ok,
    input  logic          vdda_ok,
    input  logic [CW-1:0] dly,
    output logic          enable_vddio,
    output logic          enable_h,
    output logic          enable_vdda_h,
    output logic          enable_vswitch_h,
    output logic          enable_inp_h,
    output logic          hld_h_n,
    output logic          ready,
    output logic          busy,
    output logic          fault
);

    logic             w_vio_s;
    logic             w_vda_s;
    lvl_t             w_target;
    logic             w_gate;
    lvl_t             w_lvl_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_fault_nxt;

    lvl_t             r_lvl;
    logic [CW-1:0]    r_cnt;
    logic             r_fault;
    logic [NSTEP-1:0] r_steps;
    logic             r_ready;

    la_dsync #(.PROP(PROP)) u_sync_vio (
        .clk    (clk),
        .nreset (nreset),
        .in     (vddio_ok),
        .out    (w_vio_s)
    );

    la_dsync #(.PROP(PROP)) u_sync_vda (
        .clk    (clk),
        .nreset (nreset),
        .in     (vdda_ok),
        .out    (w_vda_s)
    );

    always_comb begin
        w_target    = (en && w_vio_s && !r_fault) ? LVL_ON : LVL_OFF;
        // Only the upward 2->3 step waits for the analog supply.
        w_gate      = (r_lvl == LVL_H) && (w_target == LVL_ON) && !w_vda_s;
        w_lvl_nxt   = r_lvl;
        w_cnt_nxt   = r_cnt;
        w_fault_nxt = r_fault;

        if (!w_vio_s && (r_lvl != LVL_OFF)) begin
            w_lvl_nxt   = LVL_OFF;
            w_cnt_nxt   = '0;
            w_fault_nxt = 1'b1;
        end else begin
            if (!en) begin
                w_fault_nxt = 1'b0;
            end
            if ((r_cnt == '0) && (r_lvl != w_target) && !w_gate) begin
                w_lvl_nxt = (w_target > r_lvl) ? r_lvl + LVL_W'(1) : r_lvl - LVL_W'(1);
                w_cnt_nxt = dly;
            end else if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - CW'(1);
            end
        end
    end

    // Enables are flopped from the next level so pad controls never glitch.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_lvl   <= LVL_OFF;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_steps <= '0;
            r_ready <= 1'b0;
        end else begin
            r_lvl   <= w_lvl_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fault <= w_fault_nxt;
            r_steps <= lvl_therm(w_lvl_nxt);
            r_ready <= (w_lvl_nxt == LVL_ON);
        end
    end

    assign enable_vddio     = r_steps[0];
    assign enable_h         = r_steps[1];
    assign enable_vdda_h    = r_steps[2];
    assign enable_vswitch_h = r_steps[3];
    assign enable_inp_h     = r_steps[4];
    assign hld_h_n          = r_steps[5];
    assign ready            = r_ready;
    assign fault            = r_fault;
    assign busy             = (r_lvl != w_target) || (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_la_iosequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_la_iosequencer
// Description : Directed self-checking bench for the IO ring power sequencer.
// Revision    : 1.0
// ============================================================================
module tb_la_iosequencer;

    logic        clk;
    logic        nreset;
    logic        en;
    logic        vddio_ok;
    logic        vdda_ok;
    logic [15:0] dly;
    logic        enable_vddio, enable_h, enable_vdda_h, enable_vswitch_h;
    logic        enable_inp_h, hld_h_n, ready, busy, fault;
    logic [5:0]  steps;

    int checks   = 0;
    int failures = 0;

    la_iosequencer #(.PROP("DEFAULT"), .CW(16)) dut (
        .clk              (clk),
        .nreset           (nreset),
        .en               (en),
        .vddio_ok         (vddio_ok),
        .vdda_ok          (vdda_ok),
        .dly              (dly),
        .enable_vddio     (enable_vddio),
        .enable_h         (enable_h),
        .enable_vdda_h    (enable_vdda_h),
        .enable_vswitch_h (enable_vswitch_h),
        .enable_inp_h     (enable_inp_h),
        .hld_h_n          (hld_h_n),
        .ready            (ready),
        .busy             (busy),
        .fault            (fault)
    );

    assign steps = {hld_h_n, enable_inp_h, enable_vswitch_h, enable_vdda_h, enable_h, enable_vddio};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nreset = 1'b0; en = 1'b0; vddio_ok = 1'b1; vdda_ok = 1'b1; dly = 16'd3;
        tick(3);
        checks++;
        if ({steps, ready, busy, fault} !== 9'b0) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", {steps, ready, busy, fault}, 9'b0);
        end
        nreset = 1'b1;
        tick(3);
        checks++;
        if ({steps, ready, busy, fault} !== 9'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got %b expected %b", {steps, ready, busy, fault}, 9'b0);
        end
    endtask

    // dly=3: level k reached at edge 1+4*(k-1), ready at edge 21, idle at edge 24
    task automatic test_powerup;
        int lv;
        logic [5:0] exp;
        en = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            tick(1);
            lv  = (e - 1) / 4 + 1;
            if (lv > 6) lv = 6;
            exp = 6'((1 << lv) - 1);
            checks++;
            if (steps !== exp) begin
                failures++;
                $display("FAIL powerup_steps edge %0d: got %b expected %b", e, steps, exp);
            end
            if (e == 20 || e == 21) begin
                checks++;
                if (ready !== (e == 21)) begin
                    failures++;
                    $display("FAIL powerup_ready edge %0d: got %b expected %b", e, ready, (e == 21));
                end
            end
            if (e == 23 || e == 24) begin
                checks++;
                if (busy !== (e == 23)) begin
                    failures++;
                    $display("FAIL powerup_busy edge %0d: got %b expected %b", e, busy, (e == 23));
                end
            end
        end
    endtask

    task automatic test_powerdown;
        logic [5:0] exp;
        dly = 16'd0;
        en  = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp = 6'((1 << (6 - k)) - 1);
            checks++;
            if (steps !== exp) begin
                failures++;
                $display("FAIL powerdown_steps edge %0d: got %b expected %b", k, steps, exp);
            end
            if (k == 1) begin
                checks++;
                if (ready !== 1'b0) begin
                    failures++;
                    $display("FAIL powerdown_ready: got %b expected 0", ready);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL powerdown_idle: got busy=%b fault=%b expected busy=0 fault=0", busy, fault);
        end
    endtask

    task automatic test_vdda_gate;
        vdda_ok = 1'b0;
        tick(3);
        dly = 16'd1;
        en  = 1'b1;
        tick(10);
        for (int c = 0; c < 100; c++) begin
            checks++;
            if (steps !== 6'b000011 || busy !== 1'b1) begin
                failures++;
                $display("FAIL vdda_park cycle %0d: got steps=%b busy=%b expected steps=000011 busy=1", c, steps, busy);
            end
            tick(1);
        end
        vdda_ok = 1'b1;
        tick(2);
        checks++;
        if (steps !== 6'b000011) begin
            failures++;
            $display("FAIL vdda_still_parked: got %b expected 000011", steps);
        end
        tick(1);
        checks++;
        if (steps !== 6'b000111) begin
            failures++;
            $display("FAIL vdda_release: got %b expected 000111", steps);
        end
        tick(7);
        checks++;
        if (steps !== 6'b111111 || ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL vdda_complete: got steps=%b ready=%b busy=%b expected 111111 1 0", steps, ready, busy);
        end
    endtask

    task automatic test_supply_loss;
        vddio_ok = 1'b0;
        tick(2);
        checks++;
        if (steps !== 6'b111111 || fault !== 1'b0) begin
            failures++;
            $display("FAIL loss_sync_latency: got steps=%b fault=%b expected 111111 0", steps, fault);
        end
        tick(1);
        checks++;
        if (steps !== 6'b0 || ready !== 1'b0 || fault !== 1'b1) begin
            failures++;
            $display("FAIL loss_drop: got steps=%b ready=%b fault=%b expected 000000 0 1", steps, ready, fault);
        end
        vddio_ok = 1'b1;
        tick(6);
        checks++;
        if (steps !== 6'b0 || fault !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL loss_fault_holds: got steps=%b fault=%b busy=%b expected 000000 1 0", steps, fault, busy);
        end
        en = 1'b0;
        tick(1);
        checks++;
        if (fault !== 1'b0) begin
            failures++;
            $display("FAIL loss_fault_clear: got %b expected 0", fault);
        end
        en = 1'b1;
        tick(1);
        checks++;
        if (steps !== 6'b000001) begin
            failures++;
            $display("FAIL loss_restart: got %b expected 000001", steps);
        end
    endtask

    // dly=5: level 4 at edge 19; en drops with dly changed to 2, which must not
    // shorten the running count (level 3 at edge 25, level 2 at edge 28).
    task automatic test_reverse;
        en = 1'b0;
        tick(20);
        checks++;
        if (steps !== 6'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reverse_setup: got steps=%b busy=%b expected 000000 0", steps, busy);
        end
        dly = 16'd5;
        en  = 1'b1;
        tick(19);
        checks++;
        if (steps !== 6'b001111) begin
            failures++;
            $display("FAIL reverse_at_lvl4: got %b expected 001111", steps);
        end
        en  = 1'b0;
        dly = 16'd2;
        tick(5);
        checks++;
        if (steps !== 6'b001111 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reverse_count_runs: got steps=%b busy=%b expected 001111 1", steps, busy);
        end
        tick(1);
        checks++;
        if (steps !== 6'b000111) begin
            failures++;
            $display("FAIL reverse_vswitch_falls: got %b expected 000111", steps);
        end
        tick(2);
        checks++;
        if (steps !== 6'b000111) begin
            failures++;
            $display("FAIL reverse_new_dly_hold: got %b expected 000111", steps);
        end
        tick(1);
        checks++;
        if (steps !== 6'b000011) begin
            failures++;
            $display("FAIL reverse_new_dly_step: got %b expected 000011", steps);
        end
    endtask

    task automatic test_reset_mid;
        en = 1'b1;
        tick(5);
        nreset = 1'b0;
        #2;
        checks++;
        if ({steps, ready, busy, fault} !== 9'b0) begin
            failures++;
            $display("FAIL reset_mid_async: got %b expected %b", {steps, ready, busy, fault}, 9'b0);
        end
        nreset = 1'b1;
        tick(2);
        checks++;
        if (steps !== 6'b0) begin
            failures++;
            $display("FAIL reset_mid_resync: got %b expected 000000", steps);
        end
        tick(1);
        checks++;
        if (steps !== 6'b000001) begin
            failures++;
            $display("FAIL reset_mid_restart: got %b expected 000001", steps);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_powerdown();
        test_vdda_gate();
        test_supply_loss();
        test_reverse();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
